// File: rtl/axis_bscan_cmd_pkg.sv
// ----------------------------------------------------------------------------
// axis_bscan_cmd_pkg
//   Shared definitions for the boundary-scan command interpreter:
//   - header opcodes (NOP / WRITE / READ / ECHO)
//   - header field bit positions
//   - FSM state encoding
//   - write-acknowledge word builder
// ----------------------------------------------------------------------------
package axis_bscan_cmd_pkg;

   // Header word layout: [31:30] opcode, [29:22] LEN, [21:16] ignored,
   // [15:0] start address.
   localparam int HDR_OP_MSB   = 31;
   localparam int HDR_OP_LSB   = 30;
   localparam int HDR_LEN_MSB  = 29;
   localparam int HDR_LEN_LSB  = 22;
   localparam int HDR_ADDR_MSB = 15;
   localparam int HDR_ADDR_LSB = 0;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_WRITE = 2'b01,
      OP_READ  = 2'b10,
      OP_ECHO  = 2'b11
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_RISSUE = 3'd2,
      ST_RWAIT  = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

   // Acknowledge returned after the last word of a WRITE burst: echoes the
   // WRITE opcode and LEN, and reports the address following the burst.
   function automatic logic [31:0] make_ack(input logic [7:0]  len,
                                            input logic [15:0] final_addr);
      return {OP_WRITE, len, 6'd0, final_addr};
   endfunction

endpackage

// File: rtl/axis_bscan_cmd_outreg.sv
// ----------------------------------------------------------------------------
// axis_bscan_cmd_outreg
//   Single-entry response register driving the transmit stream.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     load, load_data     write request; honoured only when free=1
//     m_tdata, m_tvalid   registered stream output, stable while stalled
//     m_tready            downstream accept
//     free                register is empty or drains this cycle
// ----------------------------------------------------------------------------
module axis_bscan_cmd_outreg #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  free
);

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;

   // Free also covers the drain cycle so a new word can follow the
   // outgoing one without a bubble.
   assign free = !valid_q || m_tready;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (valid_q && m_tready) begin
         valid_d = 1'b0;
      end
      if (load && free) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign m_tdata  = data_q;
   assign m_tvalid = valid_q;

endmodule

// File: rtl/axis_bscan_cmd.sv
// ----------------------------------------------------------------------------
// axis_bscan_cmd
//   Host-side command interpreter for the JTAG boundary-scan stream link.
//   Decodes 32-bit command headers from the scan receive stream, runs burst
//   register writes/reads on a single-cycle register bus, and returns
//   acknowledge / read-data / echo words on the transmit stream.
//   Ports:
//     aclk, areset                    clock, asynchronous active-high reset
//     s_axis_tdata/tvalid/tready      command words in
//     m_axis_tdata/tvalid/tready      response words out
//     bus_addr, bus_wdata, bus_wren   register write (one-cycle strobe)
//     bus_rden, bus_rdata             register read; rdata one cycle later
// ----------------------------------------------------------------------------
module axis_bscan_cmd
   import axis_bscan_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic                  bus_wren,
   output logic                  bus_rden,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   state_e                state_q,     state_d;
   logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
   logic [8:0]            cnt_q,       cnt_d;      // words remaining, 1..256
   logic [7:0]            len_q,       len_d;
   logic [DATA_WIDTH-1:0] resp_q,      resp_d;     // ECHO word or WRITE ack
   logic [ADDR_WIDTH-1:0] bus_addr_q,  bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic                  bus_wren_q,  bus_wren_d;
   logic                  s_tready_q,  s_tready_d;

   logic                  s_hs;
   logic                  out_free;
   logic                  out_load;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] addr_inc;
   logic [15:0]           fin_addr16;
   opcode_e               hdr_op;

   assign s_hs     = s_axis_tvalid && s_tready_q;
   assign hdr_op   = opcode_e'(s_axis_tdata[HDR_OP_MSB:HDR_OP_LSB]);
   assign addr_inc = addr_q + 1'b1;   // wraps modulo 2^ADDR_WIDTH

   always_comb begin
      fin_addr16                   = '0;
      fin_addr16[ADDR_WIDTH-1:0]   = addr_inc;
   end

   // The read strobe is combinational so the read can launch in the same
   // cycle the output register drains; this keeps reads at one per two
   // cycles while still guaranteeing the register is empty when the data
   // returns in RWAIT.
   assign bus_rden = (state_q == ST_RISSUE) && out_free;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      resp_d      = resp_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wren_d  = 1'b0;
      out_load    = 1'b0;
      out_data    = resp_q;

      unique case (state_q)
         ST_IDLE: begin
            if (s_hs) begin
               len_d  = s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
               cnt_d  = {1'b0, s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB]} + 9'd1;
               addr_d = s_axis_tdata[HDR_ADDR_LSB +: ADDR_WIDTH];
               unique case (hdr_op)
                  OP_ECHO: begin
                     resp_d  = s_axis_tdata;
                     state_d = ST_RESP;
                  end
                  OP_WRITE: state_d = ST_WDATA;
                  OP_READ: begin
                     bus_addr_d = s_axis_tdata[HDR_ADDR_LSB +: ADDR_WIDTH];
                     state_d    = ST_RISSUE;
                  end
                  default: ;   // NOP: header consumed, nothing else
               endcase
            end
         end

         ST_WDATA: begin
            if (s_hs) begin
               bus_wren_d  = 1'b1;
               bus_addr_d  = addr_q;
               bus_wdata_d = s_axis_tdata;
               addr_d      = addr_inc;
               cnt_d       = cnt_q - 9'd1;
               if (cnt_q == 9'd1) begin
                  resp_d  = make_ack(len_q, fin_addr16);
                  state_d = ST_RESP;
               end
            end
         end

         ST_RISSUE: begin
            if (out_free) begin
               state_d = ST_RWAIT;
            end
         end

         ST_RWAIT: begin
            // Register was free when the read launched, so this load
            // always lands.
            out_load   = 1'b1;
            out_data   = bus_rdata;
            addr_d     = addr_inc;
            bus_addr_d = addr_inc;
            cnt_d      = cnt_q - 9'd1;
            state_d    = (cnt_q == 9'd1) ? ST_IDLE : ST_RISSUE;
         end

         ST_RESP: begin
            if (out_free) begin
               out_load = 1'b1;
               state_d  = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      s_tready_d = (state_d == ST_IDLE) || (state_d == ST_WDATA);
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         resp_q      <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wren_q  <= 1'b0;
         s_tready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         resp_q      <= resp_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wren_q  <= bus_wren_d;
         s_tready_q  <= s_tready_d;
      end
   end

   assign s_axis_tready = s_tready_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;
   assign bus_wren      = bus_wren_q;

   axis_bscan_cmd_outreg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_outreg (
      .clk       (aclk),
      .rst       (areset),
      .load      (out_load),
      .load_data (out_data),
      .m_tdata   (m_axis_tdata),
      .m_tvalid  (m_axis_tvalid),
      .m_tready  (m_axis_tready),
      .free      (out_free)
   );

endmodule

// File: tb/tb_axis_bscan_cmd.sv
// ----------------------------------------------------------------------------
// tb_axis_bscan_cmd
//   Directed bench: table of command bursts with hand-computed responses and
//   bus traffic, plus sequences for backpressure and mid-command reset.
// ----------------------------------------------------------------------------
module tb_axis_bscan_cmd;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic [15:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_wren;
   logic        bus_rden;
   logic [31:0] bus_rdata;

   axis_bscan_cmd #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .bus_addr      (bus_addr),
      .bus_wdata     (bus_wdata),
      .bus_wren      (bus_wren),
      .bus_rden      (bus_rden),
      .bus_rdata     (bus_rdata)
   );

   always #5 aclk = ~aclk;

   // Register model: read data = 0x100 + address, one cycle after rden;
   // garbage otherwise so mistimed captures show up.
   always @(posedge aclk) begin
      bus_rdata <= bus_rden ? (32'h100 + {16'h0, bus_addr}) : 32'hBAD0_0000;
   end

   // Monitors sample mid-cycle; inputs change only #1 after posedge.
   logic [31:0] resp_q[$];
   logic [15:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          rd_cnt;
   int          both_cnt;

   always @(negedge aclk) begin
      if (!areset) begin
         if (m_tvalid && m_tready) resp_q.push_back(m_tdata);
         if (bus_wren) begin
            wa_q.push_back(bus_addr);
            wd_q.push_back(bus_wdata);
         end
         if (bus_rden) rd_cnt++;
         if (bus_wren && bus_rden) both_cnt++;
      end
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic clear_mon();
      resp_q.delete();
      wa_q.delete();
      wd_q.delete();
      rd_cnt   = 0;
      both_cnt = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      int t = 0;
      s_tdata  = w;
      s_tvalid = 1'b1;
      @(negedge aclk);
      while (!s_tready && t < 200) begin
         @(negedge aclk);
         t++;
      end
      if (!s_tready) check($sformatf("send_ready_%h", w), {31'd0, s_tready}, 32'd1);
      @(posedge aclk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_resp(input string name, input int n);
      int t = 0;
      while (resp_q.size() < n && t < 500) begin
         @(negedge aclk);
         t++;
      end
      check({name, "_resp_cnt"}, resp_q.size(), n);
   endtask

   typedef struct {
      string            name;
      int               nwords;
      logic [4:0][31:0] words;
      int               nresp;
      logic [3:0][31:0] resp;
      int               nwr;
      logic [3:0][15:0] waddr;
      logic [3:0][31:0] wdata;
      int               nrd;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs[NV];

   initial begin
      int   t;
      int   bad;
      logic [31:0] first;

      // ---------------- vector table ----------------
      for (int v = 0; v < NV; v++) begin
         vecs[v].nwords = 0; vecs[v].words = '0;
         vecs[v].nresp  = 0; vecs[v].resp  = '0;
         vecs[v].nwr    = 0; vecs[v].waddr = '0; vecs[v].wdata = '0;
         vecs[v].nrd    = 0;
      end
      // WRITE N=1 @0x10
      vecs[0].name = "wr1";
      vecs[0].nwords = 2; vecs[0].words[0] = 32'h4000_0010; vecs[0].words[1] = 32'hDEAD_BEEF;
      vecs[0].nresp = 1;  vecs[0].resp[0] = 32'h4000_0011;
      vecs[0].nwr = 1;    vecs[0].waddr[0] = 16'h0010; vecs[0].wdata[0] = 32'hDEAD_BEEF;
      // WRITE N=4 @0xFFFE, wraps
      vecs[1].name = "wr4wrap";
      vecs[1].nwords = 5; vecs[1].words[0] = 32'h40C0_FFFE;
      vecs[1].words[1] = 32'hA1; vecs[1].words[2] = 32'hA2;
      vecs[1].words[3] = 32'hA3; vecs[1].words[4] = 32'hA4;
      vecs[1].nresp = 1;  vecs[1].resp[0] = 32'h40C0_0002;
      vecs[1].nwr = 4;
      vecs[1].waddr[0] = 16'hFFFE; vecs[1].wdata[0] = 32'hA1;
      vecs[1].waddr[1] = 16'hFFFF; vecs[1].wdata[1] = 32'hA2;
      vecs[1].waddr[2] = 16'h0000; vecs[1].wdata[2] = 32'hA3;
      vecs[1].waddr[3] = 16'h0001; vecs[1].wdata[3] = 32'hA4;
      // READ N=3 @0x20
      vecs[2].name = "rd3";
      vecs[2].nwords = 1; vecs[2].words[0] = 32'h8080_0020;
      vecs[2].nresp = 3;
      vecs[2].resp[0] = 32'h120; vecs[2].resp[1] = 32'h121; vecs[2].resp[2] = 32'h122;
      vecs[2].nrd = 3;
      // ECHO then NOP
      vecs[3].name = "echo_nop";
      vecs[3].nwords = 2; vecs[3].words[0] = 32'hC123_4567; vecs[3].words[1] = 32'h0000_0000;
      vecs[3].nresp = 1;  vecs[3].resp[0] = 32'hC123_4567;
      // READ N=1 @0xFFFF (ignored bits 21:16 set)
      vecs[4].name = "rd1top";
      vecs[4].nwords = 1; vecs[4].words[0] = 32'h803F_FFFF;
      vecs[4].nresp = 1;  vecs[4].resp[0] = 32'h0001_00FF;
      vecs[4].nrd = 1;

      // ---------------- reset state ----------------
      areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
      clear_mon();
      cycles(3);
      @(negedge aclk);
      check("rst_s_tready", {31'd0, s_tready}, 32'd0);
      check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_strobes",  {30'd0, bus_wren, bus_rden}, 32'd0);
      check("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
      check("rst_wdata",    bus_wdata, 32'd0);
      check("rst_m_tdata",  m_tdata, 32'd0);
      @(posedge aclk); #1;
      areset = 1'b0;
      cycles(2);

      // ---------------- table-driven vectors ----------------
      for (int v = 0; v < NV; v++) begin
         clear_mon();
         for (int i = 0; i < vecs[v].nwords; i++) send(vecs[v].words[i]);
         wait_resp(vecs[v].name, vecs[v].nresp);
         cycles(6);
         check({vecs[v].name, "_no_extra_resp"}, resp_q.size(), vecs[v].nresp);
         for (int i = 0; i < vecs[v].nresp; i++)
            if (i < resp_q.size())
               check($sformatf("%s_resp%0d", vecs[v].name, i), resp_q[i], vecs[v].resp[i]);
         check({vecs[v].name, "_wr_cnt"}, wa_q.size(), vecs[v].nwr);
         for (int i = 0; i < vecs[v].nwr; i++)
            if (i < wa_q.size()) begin
               check($sformatf("%s_waddr%0d", vecs[v].name, i), {16'd0, wa_q[i]}, {16'd0, vecs[v].waddr[i]});
               check($sformatf("%s_wdata%0d", vecs[v].name, i), wd_q[i], vecs[v].wdata[i]);
            end
         check({vecs[v].name, "_rd_cnt"}, rd_cnt, vecs[v].nrd);
         check({vecs[v].name, "_strobe_overlap"}, both_cnt, 0);
      end

      // ---------------- READ N=2 under backpressure ----------------
      clear_mon();
      m_tready = 1'b0;
      send(32'h8040_0040);
      t = 0;
      @(negedge aclk);
      while (!m_tvalid && t < 50) begin @(negedge aclk); t++; end
      check("bp_rd_valid", {31'd0, m_tvalid}, 32'd1);
      first = m_tdata;
      check("bp_rd_first", first, 32'h140);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         if (m_tdata !== first || m_tvalid !== 1'b1 || rd_cnt != 1) bad++;
      end
      check("bp_rd_hold", bad, 0);
      @(posedge aclk); #1;
      m_tready = 1'b1;
      wait_resp("bp_rd", 2);
      cycles(4);
      if (resp_q.size() >= 2) begin
         check("bp_rd_resp0", resp_q[0], 32'h140);
         check("bp_rd_resp1", resp_q[1], 32'h141);
      end
      check("bp_rd_rd_cnt", rd_cnt, 2);

      // ---------------- ECHO backpressure: one held, then stall ----------------
      clear_mon();
      m_tready = 1'b0;
      send(32'hC000_0001);
      send(32'hC000_0002);
      cycles(4);
      @(negedge aclk);
      check("bp_echo_stall_ready", {31'd0, s_tready}, 32'd0);
      check("bp_echo_held",        m_tdata, 32'hC000_0001);
      @(posedge aclk); #1;
      m_tready = 1'b1;
      wait_resp("bp_echo", 2);
      cycles(4);
      if (resp_q.size() >= 2) begin
         check("bp_echo_resp0", resp_q[0], 32'hC000_0001);
         check("bp_echo_resp1", resp_q[1], 32'hC000_0002);
      end

      // ---------------- reset mid-WRITE ----------------
      clear_mon();
      send(32'h40C0_0100);
      send(32'h11);
      send(32'h22);
      @(negedge aclk);
      @(posedge aclk); #1;
      areset = 1'b1;
      #1;
      check("abort_s_tready", {31'd0, s_tready}, 32'd0);
      check("abort_strobes",  {30'd0, bus_wren, bus_rden}, 32'd0);
      check("abort_bus_addr", {16'd0, bus_addr}, 32'd0);
      check("abort_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      cycles(2);
      areset = 1'b0;
      cycles(8);
      check("abort_wr_cnt",   wa_q.size(), 2);
      if (wa_q.size() >= 2) begin
         check("abort_waddr1", {16'd0, wa_q[1]}, 32'h101);
         check("abort_wdata1", wd_q[1], 32'h22);
      end
      check("abort_no_ack", resp_q.size(), 0);
      clear_mon();
      send(32'h4000_0030);
      send(32'h55);
      wait_resp("post_abort", 1);
      if (resp_q.size() >= 1) check("post_abort_ack", resp_q[0], 32'h4000_0031);
      check("post_abort_wr_cnt", wa_q.size(), 1);
      if (wa_q.size() >= 1) check("post_abort_waddr", {16'd0, wa_q[0]}, 32'h30);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
